// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle byte/half/word data-memory target for the MEM-stage load/store port.
// Optional macro DMEM_ERR_EN adds resp_err and suppresses misaligned accesses instead of aligning them down.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int AW      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_ready,
  output logic [31:0] resp_rdata,
`ifdef DMEM_ERR_EN
  output logic        resp_err,
`endif
  output logic        stall,
  output logic        busy
);

  // Handshake: the core raises req_valid with stable fields and holds it until it
  // sees resp_ready (a single-cycle pulse); fields are captured on the accepting
  // edge, so anything the core does to req_* afterwards has no effect.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [2:0]      funct3_q;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     mem_q [DEPTH];

  logic            accept;
  logic            enter_resp;
  logic            cur_we;
  logic [AW+1:0]   cur_addr;
  logic [2:0]      cur_f3;
  logic [AW-1:0]   cur_idx;
  logic [1:0]      cur_off;
  logic [31:0]     cur_word;

  logic [AW-1:0]   wr_idx;
  logic [1:0]      wr_off;
  logic [3:0]      wr_be;
  logic [31:0]     wr_data;
  logic            wr_en;

  logic            unused_addr;
  assign unused_addr = ^req_addr[31:AW+2];

  // Byte offset actually used: halfwords and words are pulled down to their natural alignment.
  function automatic logic [1:0] align_off(input logic [1:0] a, input logic [1:0] sz);
    case (sz)
      2'b00:   return a;
      2'b01:   return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] a, input logic [1:0] sz);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return (a != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] off, input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [31:0] wd, input logic [1:0] sz);
    case (sz)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // funct3[2] selects zero extension; size codes 10 and 11 both mean a full word.
  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3[1:0])
      2'b00:   return f3[2] ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return f3[2] ? {16'h0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

  assign accept = (state_q == S_IDLE) && req_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // With zero wait states RESP follows acceptance directly, so read data comes from the live request.
  assign cur_we   = (state_q == S_IDLE) ? req_we : we_q;
  assign cur_addr = (state_q == S_IDLE) ? req_addr[AW+1:0] : addr_q;
  assign cur_f3   = (state_q == S_IDLE) ? req_funct3 : funct3_q;
  assign cur_idx  = cur_addr[AW+1:2];
  assign cur_off  = align_off(cur_addr[1:0], cur_f3[1:0]);
  assign cur_word = mem_q[cur_idx];

  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

`ifdef DMEM_ERR_EN
  logic cur_mis;
  logic lat_mis;
  assign cur_mis = misaligned(cur_addr[1:0], cur_f3[1:0]);
  assign lat_mis = misaligned(addr_q[1:0], funct3_q[1:0]);
`endif

  always_comb begin
    rdata_d = 32'h0;
    if (!cur_we) begin
      rdata_d = load_ext(cur_word, cur_off, cur_f3);
    end
`ifdef DMEM_ERR_EN
    if (cur_mis) begin
      rdata_d = 32'h0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      funct3_q <= 3'b000;
      rdata_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q     <= req_we;
        addr_q   <= req_addr[AW+1:0];
        wdata_q  <= req_wdata;
        funct3_q <= req_funct3;
      end
      if (enter_resp) begin
        rdata_q <= rdata_d;
      end
    end
  end

  assign wr_idx  = addr_q[AW+1:2];
  assign wr_off  = align_off(addr_q[1:0], funct3_q[1:0]);
  assign wr_be   = lane_mask(wr_off, funct3_q[1:0]);
  assign wr_data = lane_data(wdata_q, funct3_q[1:0]);

`ifdef DMEM_ERR_EN
  assign wr_en = (state_q == S_RESP) && we_q && !lat_mis;
`else
  assign wr_en = (state_q == S_RESP) && we_q;
`endif

  // Stores land on the edge that ends RESP; a reset on that same edge cancels them.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign resp_ready = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign stall      = req_valid & ~resp_ready;
  assign busy       = (state_q != S_IDLE);

`ifdef DMEM_ERR_EN
  assign resp_err = (state_q == S_RESP) && lat_mis;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for the main checks and a
// LATENCY=0 instance for back-to-back throughput. Honours DMEM_ERR_EN when defined.
module tb_dmem_responder;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_W3 = 3'b011;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_valid0;
  logic        req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_ready, resp_ready0;
  logic [31:0] resp_rdata, resp_rdata0;
  logic        stall, stall0, busy, busy0;
`ifdef DMEM_ERR_EN
  logic        resp_err, resp_err0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(256), .LATENCY(2), .AW(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
`ifdef DMEM_ERR_EN
    .resp_err   (resp_err),
`endif
    .stall      (stall),
    .busy       (busy)
  );

  dmem_responder #(.DEPTH(256), .LATENCY(0), .AW(8)) u_dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid0),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .resp_ready (resp_ready0),
    .resp_rdata (resp_rdata0),
`ifdef DMEM_ERR_EN
    .resp_err   (resp_err0),
`endif
    .stall      (stall0),
    .busy       (busy0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete access on instance sel (0: LATENCY=2, 1: LATENCY=0). lat counts
  // negedge samples after the request is raised until resp_ready; stl counts stall-high cycles.
  task automatic access(input bit sel, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [2:0] f3,
                        output logic [31:0] rd, output logic er, output int lat, output int stl);
    logic got;
    logic rdy, st;
    @(negedge clk);
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wd;
    req_funct3 = f3;
    if (sel) req_valid0 = 1'b1;
    else     req_valid  = 1'b1;
    #1;
    st  = sel ? stall0 : stall;
    stl = st ? 1 : 0;
    lat = 0;
    got = 1'b0;
    rd  = 32'h0;
    er  = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      lat = k;
      rdy = sel ? resp_ready0 : resp_ready;
      st  = sel ? stall0 : stall;
      if (rdy) begin
        got = 1'b1;
        rd  = sel ? resp_rdata0 : resp_rdata;
`ifdef DMEM_ERR_EN
        er  = sel ? resp_err0 : resp_err;
`endif
      end else if (st) begin
        stl++;
      end
    end
    req_valid  = 1'b0;
    req_valid0 = 1'b0;
    check("ack", {31'h0, got}, 32'h1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, stl;
    int          pulses, n_seen, last;
    logic        got;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_valid0 = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_funct3 = F_W;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'h0, resp_ready}, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_busy",  {31'h0, busy}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    rst_n = 1'b1;

    // Word store then load, with latency and stall accounting.
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, F_W, rd, er, lat, stl);
    check("sw_lat",   lat, 3);
    check("sw_stall", stl, 3);
    check("sw_rdata", rd, 32'h0);
    access(0, 1'b0, 32'h10, 32'h0, F_W, rd, er, lat, stl);
    check("lw_10", rd, 32'hDEADBEEF);

    // Byte store into lane 3 and signed/unsigned byte loads.
    access(0, 1'b1, 32'h13, 32'h000000AA, F_B, rd, er, lat, stl);
    access(0, 1'b0, 32'h10, 32'h0, F_W, rd, er, lat, stl);
    check("sb_lw", rd, 32'hAAADBEEF);
    access(0, 1'b0, 32'h13, 32'h0, F_B, rd, er, lat, stl);
    check("lb_13", rd, 32'hFFFFFFAA);
    access(0, 1'b0, 32'h13, 32'h0, F_BU, rd, er, lat, stl);
    check("lbu_13", rd, 32'h000000AA);

    // Halfword store into the upper half of word 0x20.
    access(0, 1'b1, 32'h20, 32'h11223344, F_W, rd, er, lat, stl);
    access(0, 1'b1, 32'h22, 32'h00008001, F_H, rd, er, lat, stl);
    access(0, 1'b0, 32'h22, 32'h0, F_H, rd, er, lat, stl);
    check("lh_22", rd, 32'hFFFF8001);
    access(0, 1'b0, 32'h22, 32'h0, F_HU, rd, er, lat, stl);
    check("lhu_22", rd, 32'h00008001);
    access(0, 1'b0, 32'h20, 32'h0, F_W, rd, er, lat, stl);
    check("lw_20", rd, 32'h80013344);
    access(0, 1'b0, 32'h20, 32'h0, F_H, rd, er, lat, stl);
    check("lh_20", rd, 32'h00003344);
    access(0, 1'b0, 32'h21, 32'h0, F_B, rd, er, lat, stl);
    check("lb_21", rd, 32'h00000033);
    access(0, 1'b0, 32'h20, 32'h0, F_W3, rd, er, lat, stl);
    check("lw3_20", rd, 32'h80013344);

    // Reset during WAIT aborts the store.
    access(0, 1'b1, 32'h40, 32'hCAFEF00D, F_W, rd, er, lat, stl);
    @(negedge clk);
    req_we     = 1'b1;
    req_addr   = 32'h40;
    req_wdata  = 32'h12345678;
    req_funct3 = F_W;
    req_valid  = 1'b1;
    @(negedge clk);
    check("abort_busy_pre", {31'h0, busy}, 32'h1);
    rst_n     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'h0, busy}, 32'h0);
    rst_n  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (resp_ready) pulses++;
    end
    check("abort_pulses", pulses, 0);
    access(0, 1'b0, 32'h40, 32'h0, F_W, rd, er, lat, stl);
    check("abort_lw_40", rd, 32'hCAFEF00D);

    // Address wrap modulo DEPTH*4.
    access(0, 1'b1, 32'h400, 32'h0BADF00D, F_W, rd, er, lat, stl);
    access(0, 1'b0, 32'h000, 32'h0, F_W, rd, er, lat, stl);
    check("wrap_lw_0", rd, 32'h0BADF00D);

    // Misaligned accesses.
`ifdef DMEM_ERR_EN
    access(0, 1'b0, 32'h11, 32'h0, F_W, rd, er, lat, stl);
    check("mis_lw_err",   {31'h0, er}, 32'h1);
    check("mis_lw_rdata", rd, 32'h0);
    access(0, 1'b1, 32'h12, 32'h55555555, F_W, rd, er, lat, stl);
    check("mis_sw_err", {31'h0, er}, 32'h1);
    access(0, 1'b0, 32'h10, 32'h0, F_W, rd, er, lat, stl);
    check("mis_sw_nowrite", rd, 32'hAAADBEEF);
    check("ok_lw_err", {31'h0, er}, 32'h0);
`else
    access(0, 1'b0, 32'h11, 32'h0, F_W, rd, er, lat, stl);
    check("mis_lw_11", rd, 32'hAAADBEEF);
    access(0, 1'b0, 32'h13, 32'h0, F_H, rd, er, lat, stl);
    check("mis_lh_13", rd, 32'hFFFFAAAD);
`endif

    // Fields changed and req_valid dropped during WAIT do not disturb the access.
    @(negedge clk);
    req_we     = 1'b0;
    req_addr   = 32'h10;
    req_funct3 = F_W;
    req_valid  = 1'b1;
    @(negedge clk);
    req_we     = 1'b1;
    req_addr   = 32'h20;
    req_wdata  = 32'h0;
    req_funct3 = F_B;
    req_valid  = 1'b0;
    got = 1'b0;
    rd  = 32'h0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (resp_ready) begin
        got = 1'b1;
        rd  = resp_rdata;
      end
    end
    check("midchg_ack",  {31'h0, got}, 32'h1);
    check("midchg_data", rd, 32'hAAADBEEF);
    access(0, 1'b0, 32'h20, 32'h0, F_W, rd, er, lat, stl);
    check("midchg_lw_20", rd, 32'h80013344);

    // LATENCY=0: fill four words, then four loads with req_valid held high.
    for (int i = 0; i < 4; i++) begin
      access(1, 1'b1, 32'(i * 4), 32'hA5000000 | 32'(i), F_W, rd, er, lat, stl);
      if (i == 0) check("l0_lat", lat, 1);
    end
    @(negedge clk);
    req_we     = 1'b0;
    req_funct3 = F_W;
    req_addr   = 32'h0;
    req_valid0 = 1'b1;
    n_seen = 0;
    last   = 0;
    for (int k = 1; k <= 20 && n_seen < 4; k++) begin
      @(negedge clk);
      if (resp_ready0) begin
        check("b2b_data", resp_rdata0, 32'hA5000000 | 32'(n_seen));
        if (n_seen == 0) check("b2b_first", k, 1);
        else             check("b2b_gap", k - last, 2);
        last = k;
        n_seen++;
        req_addr = 32'(n_seen * 4);
      end
    end
    req_valid0 = 1'b0;
    check("b2b_count", n_seen, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
